plru_tree_controller: RTL
=========================

// Module: plru_tree_controller
// PURPOSE
//  Parametrised tree pseudo-LRU replacement controller for the set-associative L1 caches.
//  - Successor to the fixed 4-way, combinational PLRU logic.
//  - Generalised to any power-of-2 associativity and set count.
//  - State is held in clocked registers with synchronous reset.
//  - Victim lookup is a registered request/response; access updates are applied at the clock edge.
//  - Sits beside the cache controller. The controller issues victim lookups on a miss and
//    access updates on every hit or fill.
// PARAMETERS
//  ASSOC      4    ways per set; power of 2, 2..16
//  NUM_SETS   256  sets; power of 2
//  WAY_W      $clog2(ASSOC)     way-index width (derived; do not override)
//  IDX_W      $clog2(NUM_SETS)  set-index width (derived; do not override)
// PORTS
//  clk           in   1       clock
//  reset         in   1       synchronous, active-high reset
//  lkp_req       in   1       victim lookup request for set lkp_index
//  lkp_index     in   IDX_W   set to query
//  lkp_valid     out  1       victim_way valid (one-cycle pulse)
//  victim_way    out  WAY_W   way to replace
//  upd_en        in   1       access update strobe
//  upd_index     in   IDX_W   set accessed
//  upd_way       in   WAY_W   way accessed (hit or just filled)
//  way_valid     in   ASSOC   per-way valid bits of set lkp_index (used only with PLRU_VALID_PREF_EN)
// BEHAVIOUR
//  - State per set: ASSOC-1 tree bits in heap order.
//    - Node 1 is the root; node n has children 2n and 2n+1; leaves are ways 0..ASSOC-1, left to right.
//    - Bit 0 = victim lies in the left subtree; bit 1 = victim lies in the right subtree.
//  - Reset: all tree bits 0, lkp_valid=0, victim_way=0. Reset has priority over every
//    request in the same cycle.
//  - Lookup: lkp_req sampled at edge N -> lkp_valid=1 and victim_way stable for the cycle after edge N.
//    - Victim is found by walking from the root, following each node bit.
//    - lkp_valid=0 in every cycle without a request. Back-to-back requests give back-to-back responses.
//  - Update: upd_en at edge N -> every node on the path to upd_way is set to point away from upd_way.
//    - Nodes off the path are unchanged. The new state is visible from edge N.
//  - Same-cycle lookup and update on the same set: the victim is computed from the post-update
//    state (bypass).
//    - Example: ASSOC=4, reset state, upd_way=0 and lookup in the same cycle -> victim 2.
//  - Same-cycle lookup and update on different sets: independent; neither sees the other.
//  - Two updates never collide: there is one update port only.
//  - Out-of-range indices cannot occur, because the index widths are exact.
//  - Reset asserted mid-stream: a pending lookup response is dropped (lkp_valid=0 the next cycle)
//    and all sets clear.
//  - No stall or back-pressure: the block accepts one lookup and one update every cycle.
// CONFIGURATION
//  - PLRU_VALID_PREF_EN defined:
//    - If any bit of way_valid is 0 at lookup, victim_way = the lowest-numbered invalid way,
//      ignoring the tree bits.
//    - If all bits are 1, the tree walk is used.
//    - way_valid is sampled together with lkp_req.
//  - PLRU_VALID_PREF_EN undefined:
//    - way_valid is ignored (left unconnected internally); the victim is always taken from the tree.
// TESTING
//  1. ASSOC=4, reset, lookup set 0 -> victim 0. Then:
//     upd way0 -> victim 2; upd way2 -> victim 1; upd way1 -> victim 3.
//  2. ASSOC=4, updates to set 5 (way0, way2) then lookup set 6 -> victim 0 (sets isolated).
//     Lookup set 5 -> victim 1.
//  3. ASSOC=4, same-cycle upd(set3, way0) and lookup set3 -> lkp_valid next cycle, victim 2 (bypass).
//  4. ASSOC=8, reset, repeatedly update with the returned victim 8 times -> victims 0,4,2,6,1,5,3,7.
//     The 9th lookup -> 0.
//  5. Lookups every cycle on sets 0..3 -> lkp_valid held high for 4 cycles, one cycle late.
//     Assert reset with a lookup pending -> lkp_valid=0 next cycle; all victims 0 afterwards.
//  6. With PLRU_VALID_PREF_EN: state points to way1, way_valid=4'b1011 -> victim 2.
//     With way_valid=4'hF -> victim 1. Without the macro: way_valid=4'b1011 -> victim 1.

Source files
------------

// File: rtl/plru_tree_controller_if.sv
// Bus between the cache controller and the tree pseudo-LRU replacement controller.
// Carries the victim lookup request/response and the access-update strobe.
interface plru_tree_controller_if #(
  parameter int unsigned ASSOC    = 4,
  parameter int unsigned NUM_SETS = 256
);
  localparam int unsigned WAY_W = $clog2(ASSOC);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);

  logic             lkp_req;
  logic [IDX_W-1:0] lkp_index;
  logic             lkp_valid;
  logic [WAY_W-1:0] victim_way;
  logic             upd_en;
  logic [IDX_W-1:0] upd_index;
  logic [WAY_W-1:0] upd_way;
  logic [ASSOC-1:0] way_valid;

  // Cache-controller side.
  modport master (
    output lkp_req, lkp_index, upd_en, upd_index, upd_way, way_valid,
    input  lkp_valid, victim_way
  );

  // Replacement-controller side.
  modport slave (
    input  lkp_req, lkp_index, upd_en, upd_index, upd_way, way_valid,
    output lkp_valid, victim_way
  );
endinterface

// File: rtl/plru_tree_controller.sv
// Tree pseudo-LRU replacement controller: per-set heap-ordered tree bits, registered victim lookup
// with same-set update bypass. Define PLRU_VALID_PREF_EN to prefer the lowest invalid way.
module plru_tree_controller #(
  parameter int unsigned ASSOC    = 4,
  parameter int unsigned NUM_SETS = 256
) (
  input logic                   clk,
  input logic                   reset,
  plru_tree_controller_if.slave bus
);
  localparam int unsigned WAY_W = $clog2(ASSOC);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);

  // Heap-numbered nodes 1..ASSOC-1 so a node number indexes its bit directly.
  typedef logic [ASSOC-1:1] tree_t;

  tree_t            tree_q [NUM_SETS];
  tree_t            upd_tree;
  tree_t            lkp_tree;
  logic [WAY_W-1:0] victim_d;
  logic [WAY_W-1:0] victim_q;
  logic             valid_q;

  // Point every node on the path to 'way' at the opposite subtree.
  function automatic tree_t touch(tree_t t, logic [WAY_W-1:0] way);
    tree_t            r;
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] w;
    logic             dir;
    r    = t;
    node = WAY_W'(1);
    w    = way;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir     = w[WAY_W-1];
      r[node] = ~dir;
      node    = (node << 1) | WAY_W'(dir);
      w       = w << 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] walk(tree_t t);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] way;
    logic             dir;
    node = WAY_W'(1);
    way  = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      dir  = t[node];
      way  = (way << 1) | WAY_W'(dir);
      node = (node << 1) | WAY_W'(dir);
    end
    return way;
  endfunction

  always_comb begin
    upd_tree = touch(tree_q[bus.upd_index], bus.upd_way);
  end

`ifdef PLRU_VALID_PREF_EN
  logic [ASSOC-1:0] invalid;
  logic [WAY_W-1:0] scan_idx;
  logic             found;
`else
  logic unused_way_valid;
  assign unused_way_valid = ^bus.way_valid;
`endif

  always_comb begin
    lkp_tree = tree_q[bus.lkp_index];
    // A same-cycle update to the looked-up set is visible to the lookup.
    if (bus.upd_en && (bus.upd_index == bus.lkp_index)) begin
      lkp_tree = upd_tree;
    end
    victim_d = walk(lkp_tree);
`ifdef PLRU_VALID_PREF_EN
    invalid  = ~bus.way_valid;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < ASSOC; i++) begin
      if (invalid[0] && !found) begin
        victim_d = scan_idx;
        found    = 1'b1;
      end
      invalid  = invalid >> 1;
      scan_idx = scan_idx + WAY_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tree_q   <= '{default: '0};
      valid_q  <= 1'b0;
      victim_q <= '0;
    end else begin
      if (bus.upd_en) begin
        tree_q[bus.upd_index] <= upd_tree;
      end
      valid_q <= bus.lkp_req;
      if (bus.lkp_req) begin
        victim_q <= victim_d;
      end
    end
  end

  assign bus.lkp_valid  = valid_q;
  assign bus.victim_way = victim_q;
endmodule
